// File: rtl/seq_alu.sv
`default_nettype none
// ============================================================================
//  Module   : seq_alu
//  Purpose  : Sequential ALU. Single-cycle logic/arithmetic/shift ops complete
//             on the accepting edge. Signed multiply (shift-add) and signed
//             divide (restoring) iterate WIDTH cycles on operand magnitudes,
//             then a FIX cycle applies the signs.
//  Ports    : clock     rising-edge clock
//             clear     asynchronous active-high reset
//             start     request, sampled only while idle
//             opcode    operation select
//             Y, B      operands (captured on the accepting edge)
//             busy      high while a multi-cycle operation runs
//             done      one-cycle pulse, HI/LO valid
//             div_zero  sticky flag: last div had B == 0
//             HI, LO    result words
//  Revision : 1.0  initial release
// ============================================================================
module seq_alu #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic [4:0]       opcode,
  input  logic [WIDTH-1:0] Y,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int            CW     = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_SHR  = 5'b00111;
  localparam logic [4:0] OP_SHRA = 5'b01000;
  localparam logic [4:0] OP_SHL  = 5'b01001;
  localparam logic [4:0] OP_ROR  = 5'b01010;
  localparam logic [4:0] OP_ROL  = 5'b01011;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t           state_q,  state_d;
  logic [CW-1:0]    cnt_q,    cnt_d;
  logic             is_div_q, is_div_d;
  logic             neg_lo_q, neg_lo_d;   // product / quotient negative
  logic             neg_hi_q, neg_hi_d;   // remainder negative (sign of Y)
  logic [WIDTH-1:0] mag_q,    mag_d;      // |Y| for mul, |B| for div
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d;   // product high / partial remainder
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d;   // multiplier bits / quotient bits
  logic [WIDTH-1:0] hi_q,     hi_d;
  logic [WIDTH-1:0] lo_q,     lo_d;
  logic             done_q,   done_d;
  logic             dz_q,     dz_d;

  logic [SHW-1:0]     w_amt;
  logic [WIDTH-1:0]   w_abs_y, w_abs_b, w_sra, w_ror, w_rol, w_quo_s, w_rem_s;
  logic [2*WIDTH-1:0] w_dbl, w_dbl_r, w_dbl_l, w_prod, w_prod_s;
  logic [WIDTH:0]     w_mul_sum, w_div_shift, w_div_trial;

  always_comb begin
    w_amt       = B[SHW-1:0];
    // Magnitude of the most-negative value wraps to 2^(WIDTH-1), which is
    // still correct when read as unsigned.
    w_abs_y     = Y[WIDTH-1] ? -Y : Y;
    w_abs_b     = B[WIDTH-1] ? -B : B;
    w_sra       = $signed(Y) >>> w_amt;
    // Rotates via a doubled copy of Y: bits shifted out of one half land in
    // the other.
    w_dbl       = {Y, Y};
    w_dbl_r     = w_dbl >> w_amt;
    w_dbl_l     = w_dbl << w_amt;
    w_ror       = w_dbl_r[WIDTH-1:0];
    w_rol       = w_dbl_l[2*WIDTH-1:WIDTH];
    // Shift-add step: add multiplicand when the current multiplier LSB is 1,
    // then shift the whole {acc_hi, acc_lo} pair right by one.
    w_mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, mag_q} : {(WIDTH+1){1'b0}});
    // Restoring step: shift next dividend bit into the remainder, try subtract.
    w_div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
    w_div_trial = w_div_shift - {1'b0, mag_q};
    w_prod      = {acc_hi_q, acc_lo_q};
    w_prod_s    = neg_lo_q ? -w_prod : w_prod;
    w_quo_s     = neg_lo_q ? -acc_lo_q : acc_lo_q;
    w_rem_s     = neg_hi_q ? -acc_hi_q : acc_hi_q;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    mag_d    = mag_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    dz_d     = dz_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          done_d = 1'b1;
          hi_d   = '0;
          case (opcode)
            OP_ADD:  lo_d = Y + B;
            OP_SUB:  lo_d = Y - B;
            OP_AND:  lo_d = Y & B;
            OP_OR:   lo_d = Y | B;
            OP_SHR:  lo_d = Y >> w_amt;
            OP_SHRA: lo_d = w_sra;
            OP_SHL:  lo_d = Y << w_amt;
            OP_ROR:  lo_d = w_ror;
            OP_ROL:  lo_d = w_rol;
            OP_NEG:  lo_d = -B;
            OP_NOT:  lo_d = ~B;
            OP_MUL: begin
              done_d   = 1'b0;
              hi_d     = hi_q;
              state_d  = S_ITER;
              cnt_d    = '0;
              is_div_d = 1'b0;
              neg_lo_d = Y[WIDTH-1] ^ B[WIDTH-1];
              neg_hi_d = 1'b0;
              mag_d    = w_abs_y;
              acc_hi_d = '0;
              acc_lo_d = w_abs_b;
            end
            OP_DIV: begin
              if (B == '0) begin
                lo_d = '1;
                hi_d = Y;
                dz_d = 1'b1;
              end else begin
                done_d   = 1'b0;
                hi_d     = hi_q;
                state_d  = S_ITER;
                cnt_d    = '0;
                is_div_d = 1'b1;
                neg_lo_d = Y[WIDTH-1] ^ B[WIDTH-1];
                neg_hi_d = Y[WIDTH-1];
                mag_d    = w_abs_b;
                acc_hi_d = '0;
                acc_lo_d = w_abs_y;
              end
            end
            default: lo_d = '0;
          endcase
        end
      end

      S_ITER: begin
        if (is_div_q) begin
          if (!w_div_trial[WIDTH]) begin
            acc_hi_d = w_div_trial[WIDTH-1:0];
            acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b1};
          end else begin
            acc_hi_d = w_div_shift[WIDTH-1:0];
            acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b0};
          end
        end else begin
          acc_hi_d = w_mul_sum[WIDTH:1];
          acc_lo_d = {w_mul_sum[0], acc_lo_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == C_LAST) begin
          state_d = S_FIX;
        end
      end

      S_FIX: begin
        if (is_div_q) begin
          lo_d = w_quo_s;
          hi_d = w_rem_s;
          dz_d = 1'b0;
        end else begin
          {hi_d, lo_d} = w_prod_s;
        end
        done_d  = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      mag_q    <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      mag_q    <= mag_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
      dz_q     <= dz_d;
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign done     = done_q;
  assign div_zero = dz_q;
  assign HI       = hi_q;
  assign LO       = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_alu.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seq_alu
//  Purpose  : Self-checking bench for seq_alu (WIDTH=32). An arithmetic model
//             predicts every output each cycle; directed vectors also carry
//             hand-computed literal results.
//  Revision : 1.0  initial release
// ============================================================================
module tb_seq_alu;
  localparam int W = 32;

  localparam logic [4:0] ADD = 5'b00011, SUB = 5'b00100, AND = 5'b00101, OR_ = 5'b00110;
  localparam logic [4:0] SHR = 5'b00111, SRA = 5'b01000, SHL = 5'b01001, ROR = 5'b01010;
  localparam logic [4:0] ROL = 5'b01011, MUL = 5'b01111, DIV = 5'b10000, NEG = 5'b10001;
  localparam logic [4:0] NOT = 5'b10010;

  logic         clock = 1'b0;
  logic         clear;
  logic         start;
  logic [4:0]   opcode;
  logic [W-1:0] Y, B;
  logic         busy, done, div_zero;
  logic [W-1:0] HI, LO;

  int n_checks = 0;
  int n_pass   = 0;

  seq_alu #(.WIDTH(W)) dut (
    .clock(clock), .clear(clear), .start(start), .opcode(opcode),
    .Y(Y), .B(B), .busy(busy), .done(done), .div_zero(div_zero),
    .HI(HI), .LO(LO)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic         multi;
    logic [1:0]   dz;     // 0 keep, 1 set, 2 clear
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } res_t;

  function automatic res_t model_op(input logic [4:0] op, input logic [W-1:0] y, input logic [W-1:0] b);
    res_t r;
    logic [63:0] p;
    longint sy, sb, q, rm;
    int a;
    r  = '0;
    a  = int'(b[4:0]);
    sy = longint'($signed(y));
    sb = longint'($signed(b));
    case (op)
      ADD: r.lo = y + b;
      SUB: r.lo = y - b;
      AND: r.lo = y & b;
      OR_: r.lo = y | b;
      SHR: r.lo = y >> a;
      SRA: begin q = sy >>> a; r.lo = q[31:0]; end
      SHL: r.lo = y << a;
      ROR: r.lo = (y >> a) | (y << (W - a));
      ROL: r.lo = (y << a) | (y >> (W - a));
      NEG: r.lo = -b;
      NOT: r.lo = ~b;
      MUL: begin r.multi = 1'b1; p = sy * sb; r.hi = p[63:32]; r.lo = p[31:0]; end
      DIV: begin
        if (b == '0) begin
          r.lo = '1; r.hi = y; r.dz = 2'd1;
        end else begin
          r.multi = 1'b1; r.dz = 2'd2;
          q = sy / sb; rm = sy % sb;
          r.lo = q[31:0]; r.hi = rm[31:0];
        end
      end
      default: ;
    endcase
    return r;
  endfunction

  res_t         r_now, pend;
  int           m_left;
  logic         e_done, e_dz;
  logic [W-1:0] e_hi, e_lo;

  always_comb r_now = model_op(opcode, Y, B);

  // m_left: edges remaining until a multi-cycle result appears.
  always @(posedge clock or posedge clear) begin
    if (clear) begin
      m_left <= 0; e_done <= 1'b0; e_dz <= 1'b0; e_hi <= '0; e_lo <= '0; pend <= '0;
    end else begin
      e_done <= 1'b0;
      if (m_left != 0) begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          e_hi <= pend.hi; e_lo <= pend.lo; e_done <= 1'b1;
          if (pend.dz == 2'd2) e_dz <= 1'b0;
        end
      end else if (start) begin
        if (r_now.multi) begin
          m_left <= W + 1;
          pend   <= r_now;
        end else begin
          e_hi <= r_now.hi; e_lo <= r_now.lo; e_done <= 1'b1;
          if (r_now.dz == 2'd1) e_dz <= 1'b1;
        end
      end
    end
  end

  always @(negedge clock) begin
    check("busy", busy, m_left != 0);
    check("done", done, e_done);
    check("div_zero", div_zero, e_dz);
    check("HI", HI, e_hi);
    check("LO", LO, e_lo);
  end

  // ---------------- stimulus ----------------
  task automatic issue(input logic [4:0] op, input logic [W-1:0] y, input logic [W-1:0] b);
    start = 1'b1; opcode = op; Y = y; B = b;
    @(posedge clock);
    #1;
    start = 1'b0; opcode = 5'($urandom); Y = $urandom; B = $urandom;
  endtask

  task automatic wait_done(output int cyc, output int nbusy);
    cyc = 0; nbusy = 0;
    while (cyc < 100) begin
      @(negedge clock);
      cyc++;
      if (busy) nbusy++;
      if (done) break;
    end
    #1;
  endtask

  logic [4:0]   t_op [12] = '{SUB, AND, OR_, SHR, SHL, ROR, NEG, NOT, 5'b11111, MUL, DIV, DIV};
  logic [W-1:0] t_y  [12] = '{32'd5, 32'hF0F0_1234, 32'h0F00_0001, 32'h8000_0000, 32'h0000_0003,
                              32'h0000_0001, 32'h0, 32'h1234_5678, 32'hDEAD_BEEF, 32'h8000_0000,
                              32'd100, 32'd7};
  logic [W-1:0] t_b  [12] = '{32'd7, 32'hFF00_FF00, 32'h00F0_0010, 32'h0000_001F, 32'h0000_0020,
                              32'h0000_0001, 32'd5, 32'h0, 32'h1, 32'h8000_0000,
                              32'hFFFF_FFF9, 32'hFFFF_FF9C};

  initial begin
    int cyc, nb, nd;
    res_t r;
    clear = 1'b1; start = 1'b0; opcode = '0; Y = '0; B = '0;
    repeat (3) @(posedge clock);
    #1 clear = 1'b0;
    @(negedge clock); #1;
    check("rst_HI", HI, 0); check("rst_LO", LO, 0);
    check("rst_busy", busy, 0); check("rst_dz", div_zero, 0);

    // add wraps
    issue(ADD, 32'hFFFF_FFFF, 32'd1);
    wait_done(cyc, nb);
    check("add_lat", cyc, 1); check("add_busy", nb, 0);
    check("add_LO", LO, 0); check("add_HI", HI, 0);

    // signed multiply
    issue(MUL, 32'hFFFF_FFFD, 32'd7);
    wait_done(cyc, nb);
    check("mul_lat", cyc, 34); check("mul_busy", nb, 33);
    check("mul_HI", HI, 32'hFFFF_FFFF); check("mul_LO", LO, 32'hFFFF_FFEB);

    // signed divide, then divide by zero
    issue(DIV, 32'hFFFF_FFF9, 32'd2);
    wait_done(cyc, nb);
    check("div_lat", cyc, 34);
    check("div_LO", LO, 32'hFFFF_FFFD); check("div_HI", HI, 32'hFFFF_FFFF); check("div_dz", div_zero, 0);
    issue(DIV, 32'd5, 32'd0);
    wait_done(cyc, nb);
    check("dz_lat", cyc, 1); check("dz_LO", LO, 32'hFFFF_FFFF);
    check("dz_HI", HI, 32'd5); check("dz_flag", div_zero, 1);

    // shifts/rotates; div_zero must stay sticky through them
    issue(SRA, 32'h8000_0000, 32'h0000_0024);
    wait_done(cyc, nb);
    check("sra_LO", LO, 32'hF800_0000); check("sra_dz", div_zero, 1);
    issue(ROL, 32'h8000_0001, 32'd1);
    wait_done(cyc, nb);
    check("rol_LO", LO, 32'h0000_0003);

    // directed table, model-checked each cycle plus latency
    for (int i = 0; i < 12; i++) begin
      r = model_op(t_op[i], t_y[i], t_b[i]);
      issue(t_op[i], t_y[i], t_b[i]);
      wait_done(cyc, nb);
      check("tbl_lat", cyc, r.multi ? 34 : 1);
    end
    check("sub_model", 64'(model_op(SUB, 32'd5, 32'd7).lo), 32'hFFFF_FFFE);

    // abort: second start ignored, clear mid-ITER, no done afterwards
    issue(MUL, 32'd1234, 32'd5678);
    repeat (9) @(posedge clock);
    #1 start = 1'b1; opcode = ADD; Y = 32'd1; B = 32'd1;
    @(posedge clock);
    #1 start = 1'b0;
    repeat (9) @(posedge clock);
    #1 clear = 1'b1;
    repeat (2) @(posedge clock);
    #1 clear = 1'b0;
    @(negedge clock); #1;
    check("abort_HI", HI, 0); check("abort_LO", LO, 0); check("abort_busy", busy, 0);
    nd = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (done) nd++;
    end
    #1;
    check("abort_no_done", nd, 0);

    // first start after clear is accepted
    issue(ADD, 32'd1, 32'd2);
    wait_done(cyc, nb);
    check("post_clr_lat", cyc, 1); check("post_clr_LO", LO, 3);

    // most-negative / -1, then back-to-back add in the done cycle
    issue(DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(cyc, nb);
    check("ovf_lat", cyc, 34);
    check("ovf_LO", LO, 32'h8000_0000); check("ovf_HI", HI, 0); check("ovf_dz", div_zero, 0);
    issue(ADD, 32'd10, 32'd20);
    wait_done(cyc, nb);
    check("b2b_lat", cyc, 1); check("b2b_LO", LO, 32'd30);

    repeat (3) @(negedge clock);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
